// File: rtl/tank_pos_sched_if.sv
// Target handshake bundle between the position requesters (local mouse, remote UART)
// and the tank position scheduler.
interface tank_pos_sched_if;
  logic        loc_valid;
  logic [11:0] loc_x;
  logic [11:0] loc_y;
  logic        loc_ready;
  logic        rem_valid;
  logic [9:0]  rem_x;
  logic [9:0]  rem_y;
  logic        rem_ready;

  modport master (
    output loc_valid, loc_x, loc_y, rem_valid, rem_x, rem_y,
    input  loc_ready, rem_ready
  );

  modport slave (
    input  loc_valid, loc_x, loc_y, rem_valid, rem_x, rem_y,
    output loc_ready, rem_ready
  );
endinterface

// File: rtl/tank_pos_sched.sv
// Once-per-frame, slew-limited commit of two tank positions during vertical blanking,
// sharing a single step unit between the tanks in round-robin order.
module tank_pos_sched #(
  parameter int unsigned SCREEN_W = 800,
  parameter int unsigned SCREEN_H = 600,
  parameter int unsigned TANK_W   = 64,
  parameter int unsigned TANK_H   = 64,
  parameter int unsigned STEP_MAX = 4,
  parameter int unsigned A_X0     = 100,
  parameter int unsigned A_Y0     = 500,
  parameter int unsigned B_X0     = 600,
  parameter int unsigned B_Y0     = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vblnk,
  input  logic               SelectMode,
  tank_pos_sched_if.slave    req,
  output logic [11:0]        tankA_x,
  output logic [11:0]        tankA_y,
  output logic [11:0]        tankB_x,
  output logic [11:0]        tankB_y,
  output logic               frame_tick,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CMT0, CMT1, WAIT_END} state_t;

  localparam logic [11:0]        X_MAX  = 12'(SCREEN_W - TANK_W);
  localparam logic [11:0]        Y_MAX  = 12'(SCREEN_H - TANK_H);
  localparam logic signed [12:0] STEP_S = 13'(STEP_MAX);

  state_t      r_state, w_next;
  logic        r_prio, r_vblnk_d, r_tick;
  logic [11:0] r_ax, r_ay, r_bx, r_by;
  logic [11:0] r_tax, r_tay, r_tbx, r_tby;
  logic        w_ready, w_commit, w_sel_b;
  logic [11:0] w_cur_x, w_cur_y, w_tgt_x, w_tgt_y, w_nx, w_ny;

  function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [11:0] step_axis(input logic [11:0] cur, input logic [11:0] tgt);
    logic signed [12:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (d > STEP_S)       return cur + 12'(STEP_MAX);
    else if (d < -STEP_S) return cur - 12'(STEP_MAX);
    else                  return tgt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (vblnk && !r_vblnk_d) w_next = CMT0;
      CMT0:     w_next = CMT1;
      CMT1:     w_next = WAIT_END;
      WAIT_END: if (!vblnk) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state == CMT0) || (r_state == CMT1);
    w_ready  = !rst && !busy;
    w_commit = busy && SelectMode;
  end

  assign req.loc_ready = w_ready;
  assign req.rem_ready = w_ready;

  // prio picks the tank for CMT0; CMT1 serves the other one
  assign w_sel_b = (r_state == CMT0) ? r_prio : ~r_prio;
  assign w_cur_x = w_sel_b ? r_bx  : r_ax;
  assign w_cur_y = w_sel_b ? r_by  : r_ay;
  assign w_tgt_x = w_sel_b ? r_tbx : r_tax;
  assign w_tgt_y = w_sel_b ? r_tby : r_tay;
  assign w_nx    = step_axis(w_cur_x, w_tgt_x);
  assign w_ny    = step_axis(w_cur_y, w_tgt_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_d <= vblnk;  // a level already high at release must not look like an edge
      r_prio    <= 1'b0;
      r_tick    <= 1'b0;
      r_ax  <= 12'(A_X0);  r_ay  <= 12'(A_Y0);
      r_bx  <= 12'(B_X0);  r_by  <= 12'(B_Y0);
      r_tax <= 12'(A_X0);  r_tay <= 12'(A_Y0);
      r_tbx <= 12'(B_X0);  r_tby <= 12'(B_Y0);
    end else begin
      r_vblnk_d <= vblnk;
      r_tick    <= (r_state == CMT1);
      if (r_state == CMT1) r_prio <= ~r_prio;
      if (w_commit) begin
        if (w_sel_b) begin
          r_bx <= w_nx;  r_by <= w_ny;
        end else begin
          r_ax <= w_nx;  r_ay <= w_ny;
        end
      end
      if (req.loc_valid && w_ready) begin
        r_tax <= clamp(req.loc_x, X_MAX);
        r_tay <= clamp(req.loc_y, Y_MAX);
      end
      if (req.rem_valid && w_ready) begin
        r_tbx <= clamp({2'b00, req.rem_x}, X_MAX);
        r_tby <= clamp({2'b00, req.rem_y}, Y_MAX);
      end
    end
  end

  assign tankA_x    = r_ax;
  assign tankA_y    = r_ay;
  assign tankB_x    = r_bx;
  assign tankB_y    = r_by;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_tank_pos_sched.sv
// Bench for tank_pos_sched: frame-level vector table, directed corner sequences and
// randomized traffic, all checked every cycle against a behavioural position model.
module tb_tank_pos_sched;

  logic        clk = 1'b0;
  logic        rst, vblnk, SelectMode;
  logic [11:0] tankA_x, tankA_y, tankB_x, tankB_y;
  logic        frame_tick, busy;

  tank_pos_sched_if bus();

  tank_pos_sched #(
    .SCREEN_W(800), .SCREEN_H(600), .TANK_W(64), .TANK_H(64), .STEP_MAX(4),
    .A_X0(100), .A_Y0(500), .B_X0(600), .B_Y0(500)
  ) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .SelectMode(SelectMode), .req(bus),
    .tankA_x(tankA_x), .tankA_y(tankA_y), .tankB_x(tankB_x), .tankB_y(tankB_y),
    .frame_tick(frame_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model: positions and targets as plain integers, plus the
  // number of cycles elapsed in the current blanking window.
  int m_ax, m_ay, m_bx, m_by, m_tax, m_tay, m_tbx, m_tby;
  int m_prio, m_phase, m_vprev, m_tick;

  function automatic int mstep(int cur, int tgt);
    int d = tgt - cur;
    if (d > 4)  return cur + 4;
    if (d < -4) return cur - 4;
    return tgt;
  endfunction

  function automatic int lim(int v, int l);
    return (v > l) ? l : v;
  endfunction

  task automatic commit_one(int tank_b);
    if (SelectMode) begin
      if (tank_b != 0) begin m_bx = mstep(m_bx, m_tbx); m_by = mstep(m_by, m_tby); end
      else             begin m_ax = mstep(m_ax, m_tax); m_ay = mstep(m_ay, m_tay); end
    end
  endtask

  task automatic model_update();
    bit open;
    if (rst) begin
      m_ax = 100; m_ay = 500; m_bx = 600; m_by = 500;
      m_tax = 100; m_tay = 500; m_tbx = 600; m_tby = 500;
      m_prio = 0; m_phase = 0; m_tick = 0; m_vprev = int'(vblnk);
      return;
    end
    open = (m_phase == 0 || m_phase == 3);
    if (open && bus.loc_valid) begin m_tax = lim(int'(bus.loc_x), 736); m_tay = lim(int'(bus.loc_y), 536); end
    if (open && bus.rem_valid) begin m_tbx = lim(int'(bus.rem_x), 736); m_tby = lim(int'(bus.rem_y), 536); end
    m_tick = (m_phase == 2) ? 1 : 0;
    case (m_phase)
      0: if (vblnk && m_vprev == 0) m_phase = 1;
      1: begin commit_one(m_prio); m_phase = 2; end
      2: begin commit_one(1 - m_prio); m_prio = 1 - m_prio; m_phase = 3; end
      default: if (!vblnk) m_phase = 0;
    endcase
    m_vprev = int'(vblnk);
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    int rdy;
    model_update();
    @(posedge clk);
    #1;
    rdy = (!rst && (m_phase == 0 || m_phase == 3)) ? 1 : 0;
    chk("tankA_x", int'(tankA_x), m_ax);
    chk("tankA_y", int'(tankA_y), m_ay);
    chk("tankB_x", int'(tankB_x), m_bx);
    chk("tankB_y", int'(tankB_y), m_by);
    chk("frame_tick", int'(frame_tick), m_tick);
    chk("busy", int'(busy), (m_phase == 1 || m_phase == 2) ? 1 : 0);
    chk("loc_ready", int'(bus.loc_ready), rdy);
    chk("rem_ready", int'(bus.rem_ready), rdy);
  endtask

  task automatic run_frame(logic lv, int lx, int ly, logic rv, int rx, int ry, logic sel);
    SelectMode = sel;
    bus.loc_valid = lv; bus.loc_x = 12'(lx); bus.loc_y = 12'(ly);
    bus.rem_valid = rv; bus.rem_x = 10'(rx); bus.rem_y = 10'(ry);
    vblnk = 1'b0;
    cyc();
    bus.loc_valid = 1'b0; bus.rem_valid = 1'b0;
    vblnk = 1'b1;
    repeat (6) cyc();
    vblnk = 1'b0;
    repeat (3) cyc();
  endtask

  typedef struct {
    logic lv; int lx; int ly;
    logic rv; int rx; int ry;
    logic sel;
    int ax; int ay; int bx; int by;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0,    0,    0, 1'b0,    0,   0, 1'b1, 100, 500, 600, 500};
    tbl[1] = '{1'b1,  110,  500, 1'b0,    0,   0, 1'b1, 104, 500, 600, 500};
    tbl[2] = '{1'b0,    0,    0, 1'b0,    0,   0, 1'b1, 108, 500, 600, 500};
    tbl[3] = '{1'b0,    0,    0, 1'b0,    0,   0, 1'b1, 110, 500, 600, 500};
    tbl[4] = '{1'b0,    0,    0, 1'b1, 1000, 900, 1'b1, 110, 500, 604, 504};
    tbl[5] = '{1'b1, 2000, 4095, 1'b0,    0,   0, 1'b0, 110, 500, 604, 504};
    tbl[6] = '{1'b0,    0,    0, 1'b0,    0,   0, 1'b1, 114, 504, 608, 508};
    tbl[7] = '{1'b1,    0,    0, 1'b0,    0,   0, 1'b1, 110, 500, 612, 512};
    tbl[8] = '{1'b1,  200,  100, 1'b1,  100, 100, 1'b1, 114, 496, 608, 508};

    rst = 1'b1; vblnk = 1'b0; SelectMode = 1'b1;
    bus.loc_valid = 1'b0; bus.loc_x = '0; bus.loc_y = '0;
    bus.rem_valid = 1'b0; bus.rem_x = '0; bus.rem_y = '0;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (2) cyc();

    foreach (tbl[i]) begin
      run_frame(tbl[i].lv, tbl[i].lx, tbl[i].ly, tbl[i].rv, tbl[i].rx, tbl[i].ry, tbl[i].sel);
      chk($sformatf("vec%0d_ax", i), int'(tankA_x), tbl[i].ax);
      chk($sformatf("vec%0d_ay", i), int'(tankA_y), tbl[i].ay);
      chk($sformatf("vec%0d_bx", i), int'(tankB_x), tbl[i].bx);
      chk($sformatf("vec%0d_by", i), int'(tankB_y), tbl[i].by);
    end

    // Requests offered only while committing must be refused.
    vblnk = 1'b1;
    cyc();
    bus.loc_valid = 1'b1; bus.loc_x = 12'd700; bus.loc_y = 12'd100;
    cyc();
    chk("hold_loc_ready_cmt", int'(bus.loc_ready), 0);
    cyc();
    bus.loc_valid = 1'b0;
    vblnk = 1'b0;
    repeat (3) cyc();
    run_frame(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);

    // Reset in the first commit cycle discards the frame.
    vblnk = 1'b1;
    cyc();
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    cyc();
    chk("rst_ax", int'(tankA_x), 100);
    chk("rst_ay", int'(tankA_y), 500);
    chk("rst_bx", int'(tankB_x), 600);
    chk("rst_by", int'(tankB_y), 500);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("no_tick_after_rst", int'(frame_tick), 0);
      chk("no_busy_vblnk_high", int'(busy), 0);
    end
    vblnk = 1'b0;
    repeat (2) cyc();

    // Remote target far away: x takes 34 frames, y takes 9.
    run_frame(1'b0, 0, 0, 1'b1, 1000, 900, 1'b1);
    for (int f = 1; f < 33; f++) run_frame(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    chk("far_bx_33", int'(tankB_x), 732);
    chk("far_by_33", int'(tankB_y), 536);
    run_frame(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    chk("far_bx_34", int'(tankB_x), 736);
    chk("far_by_34", int'(tankB_y), 536);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) vblnk = ~vblnk;
      rst        = ($urandom_range(0, 149) == 0);
      SelectMode = ($urandom_range(0, 7) != 0);
      bus.loc_valid = ($urandom_range(0, 3) == 0);
      bus.loc_x = 12'($urandom_range(0, 4095));
      bus.loc_y = 12'($urandom_range(0, 4095));
      bus.rem_valid = ($urandom_range(0, 3) == 0);
      bus.rem_x = 10'($urandom_range(0, 1023));
      bus.rem_y = 10'($urandom_range(0, 1023));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tank_pos_sched.md
# tank_pos_sched

Per-frame scheduler for the tank position registers that feed the tank drawing pipeline. It accepts position targets from two requesters: the local mouse path and the remote 10-bit UART coordinates. Each target is clamped to the playfield. Once per frame, during vertical blanking, the block commits one slew-limited step per tank through a single shared update unit, so drawn positions never change mid-frame. Its outputs drive the posX/posY inputs of the own-tank and enemy-tank draw stages.

## Interface
Parameters:
- SCREEN_W, 800, visible width in pixels
- SCREEN_H, 600, visible height in pixels
- TANK_W, 64, sprite width
- TANK_H, 64, sprite height
- STEP_MAX, 4, maximum movement per frame per axis, in pixels (1..63)
- A_X0 / A_Y0, 100 / 500, own-tank reset position
- B_X0 / B_Y0, 600 / 500, enemy-tank reset position

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vblnk  in  1  vertical blanking from the timing chain
- SelectMode  in  1  1 = game running (commits enabled), 0 = positions frozen
- loc_valid  in  1  local target valid
- loc_x, loc_y  in  12  local target, in pixels
- loc_ready  out  1  local target accepted when valid & ready
- rem_valid  in  1  remote target valid
- rem_x, rem_y  in  10  remote target, zero-extended to 12 bits
- rem_ready  out  1  remote target accepted when valid & ready
- tankA_x, tankA_y  out  12  committed own-tank position
- tankB_x, tankB_y  out  12  committed enemy-tank position
- frame_tick  out  1  one-cycle pulse after each commit window
- busy  out  1  high while in the commit states

## Operation
- Target registers tgtA (loaded from loc) and tgtB (loaded from rem) are written on valid & ready. A new write overwrites the old target; there is no queue.
- Clamp on write: x = min(in_x, SCREEN_W-TANK_W), y = min(in_y, SCREEN_H-TANK_H). Comparison is unsigned, 12 bits.
- Ready: loc_ready = rem_ready = 1 in IDLE and WAIT_END, 0 in CMT0/CMT1. This guarantees a target never changes while it is being committed.
- Shared step unit, per axis: d = tgt - cur. If |d| <= STEP_MAX then cur = tgt; otherwise cur = cur ± STEP_MAX toward tgt. Use 13-bit signed arithmetic, no wrap.
- FSM states:
  - IDLE: when the vblnk rising edge is seen (vblnk=1, registered previous value 0), go to CMT0.
  - CMT0: commit the first tank in priority order; go to CMT1.
  - CMT1: commit the second tank; pulse frame_tick; go to WAIT_END.
  - WAIT_END: when vblnk=0, go to IDLE.
- Priority: round-robin register prio. prio=0 orders A then B; prio=1 orders B then A. prio toggles on every CMT1.
- SelectMode=0: CMT0 and CMT1 are still traversed and frame_tick still pulses, but the tank registers hold and prio still toggles.
- busy = (state == CMT0 || state == CMT1).

## Timing
- Reset values:
  - state = IDLE, prio = 0
  - tankA = (A_X0, A_Y0), tankB = (B_X0, B_Y0)
  - tgtA = tankA, tgtB = tankB
  - frame_tick = 0, busy = 0, ready = 0 during rst
- Cycle t: vblnk rising edge seen in IDLE.
- Cycle t+1: state = CMT0. The first tank's registered outputs change at the end of this cycle.
- Cycle t+2: state = CMT1. The second tank updates at the end of this cycle.
- frame_tick is high in cycle t+3, for exactly one cycle.
- A write accepted at cycle n takes effect at the next commit whose CMT state starts after cycle n.
- A vblnk edge arriving while in WAIT_END is ignored (no double commit). vblnk already high at reset release does not trigger a commit.
- Both requesters valid in the same cycle: both are accepted (separate target registers). Arbitration applies only to the shared step unit.
- rst asserted mid-commit: the next cycle shows reset values; a partial step is discarded.

## Test plan
- Reset, then idle frames with no requests: outputs stay at (100,500)/(600,500); frame_tick pulses once per frame, 3 cycles after each vblnk rise.
- loc target (110,500): tankA_x goes 104, 108, 110 over 3 frames; tankA_y stays 500.
- rem target (1000, 900), 10-bit masked to (1000, 900&1023): tgtB clamps to (736, 536); tankB reaches it in ceil(136/4)=34 frames (x) and 9 frames (y).
- Both valid in the same cycle, then vblnk: both accepted. In frame 1, A updates at t+1 and B at t+2; in frame 2, B updates at t+1 and A at t+2.
- loc_valid held high across a commit: loc_ready=0 in CMT0/CMT1 and nothing is accepted there. SelectMode=0 freezes tanks; frame_tick still pulses.
- rst asserted in CMT0: all positions return to reset values the next cycle, and no frame_tick is issued for that frame.
